// File: rtl/tms9900_bus_master.sv
// TMS9900 console-bus initiator: one word request becomes one memory cycle with two byte windows.
// Build option BUS_MASTER_READY_EN: honour ready, count extension periods, abort after TIMEOUT.
//  state   | meaning
//  IDLE    | waiting for a request handshake
//  ACCEPT  | request latched, waiting for the next tick to open the cycle
//  ADDR    | memen low, address setup for one T
//  HI      | high byte window, a15=0
//  LO      | low byte window, a15=1
//  END     | memen high, one idle T before accepting again
module tms9900_bus_master #(
   parameter int CLK_PER_PHASE = 2,
   parameter int WAIT_STATES   = 2,
   parameter int TIMEOUT       = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic        phi3,
   output logic        memen,
   output logic        dbin,
   output logic        we,
   output logic        a15,
   output logic [15:0] o_address,
   output logic [7:0]  o_data,
   output logic        o_data_oe,
   input  logic [7:0]  i_data,
   input  logic        ready
);
   localparam int DIV_W = (CLK_PER_PHASE > 1) ? $clog2(CLK_PER_PHASE) : 1;
   localparam int WIN_W = $clog2(WAIT_STATES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_PHASE - 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WAIT_STATES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ACCEPT, S_ADDR, S_HI, S_LO, S_END
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [1:0]        qtr_q, qtr_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic              wr_q, wr_d;
   logic [14:0]       radr_q, radr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [15:0]       rbuf_q, rbuf_d;
   logic              phi3_q, memen_q, memen_d, dbin_q, dbin_d, we_q, we_d, a15_q, a15_d;
   logic [14:0]       oaddr_q, oaddr_d;
   logic [7:0]        odata_q, odata_d;
   logic              oe_q, oe_d;
   logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
   logic [15:0]       resp_rdata_q, resp_rdata_d;
   logic              div_wrap, tick, pre_tick;
   logic              ready_ok, timeout_hit, ext_step, clr_wait, finish, abort;

   always_comb begin
      div_wrap = (div_q == DIV_LAST);
      div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
      qtr_d    = div_wrap ? qtr_q + 2'd1 : qtr_q;
      tick     = (div_q == '0) && (qtr_q == 2'd0);
      pre_tick = div_wrap && (qtr_q == 2'd3);
   end

`ifdef BUS_MASTER_READY_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] wait_q;
   logic            unused_ok;

   assign ready_ok    = ready;
   assign timeout_hit = (wait_q == TO_W'(TIMEOUT));
   assign unused_ok   = &{1'b0, req_addr[0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          wait_q <= '0;
      else if (clr_wait)                  wait_q <= '0;
      else if (ext_step && !timeout_hit)  wait_q <= wait_q + TO_W'(1);
   end
`else
   logic unused_ok;

   assign ready_ok    = 1'b1;
   assign timeout_hit = 1'b0;
   assign unused_ok   = &{1'b0, req_addr[0], ready, ext_step, clr_wait};
`endif

   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      wr_d         = wr_q;
      radr_d       = radr_q;
      wdata_d      = wdata_q;
      rbuf_d       = rbuf_q;
      memen_d      = memen_q;
      dbin_d       = dbin_q;
      we_d         = we_q;
      a15_d        = a15_q;
      oaddr_d      = oaddr_q;
      odata_d      = odata_q;
      oe_d         = oe_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      ext_step     = 1'b0;
      clr_wait     = 1'b0;
      finish       = 1'b0;
      abort        = 1'b0;

      // Read bytes are captured one clk before the tick that may close the window.
      if (pre_tick && state_q == S_HI) rbuf_d[15:8] = i_data;
      if (pre_tick && state_q == S_LO) rbuf_d[7:0]  = i_data;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_ACCEPT;
               wr_d    = req_write;
               radr_d  = req_addr[15:1];
               wdata_d = req_wdata;
            end
         end
         S_ACCEPT: begin
            if (tick) begin
               state_d  = S_ADDR;
               memen_d  = 1'b0;
               dbin_d   = !wr_q;
               a15_d    = 1'b0;
               oaddr_d  = radr_q;
               win_d    = '0;
               clr_wait = 1'b1;
            end
         end
         S_ADDR: begin
            if (tick) begin
               state_d = S_HI;
               win_d   = '0;
               if (wr_q) begin
                  odata_d = wdata_q[15:8];
                  oe_d    = 1'b1;
               end
            end
         end
         S_HI, S_LO: begin
            if (tick) begin
               if (win_q != WIN_LAST) begin
                  win_d = win_q + WIN_W'(1);
                  we_d  = !wr_q;
               end else if (!ready_ok) begin
                  ext_step = 1'b1;
                  if (timeout_hit) begin
                     finish = 1'b1;
                     abort  = 1'b1;
                  end
               end else if (state_q == S_HI) begin
                  state_d = S_LO;
                  win_d   = '0;
                  we_d    = 1'b1;
                  a15_d   = 1'b1;
                  if (wr_q) odata_d = wdata_q[7:0];
               end else begin
                  finish = 1'b1;
               end
            end
         end
         S_END: begin
            if (tick) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (finish) begin
         state_d      = S_END;
         memen_d      = 1'b1;
         dbin_d       = 1'b0;
         we_d         = 1'b1;
         oe_d         = 1'b0;
         a15_d        = 1'b0;
         resp_valid_d = 1'b1;
         resp_err_d   = abort;
         if (!wr_q && !abort) resp_rdata_d = rbuf_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         qtr_q        <= 2'd0;
         win_q        <= '0;
         wr_q         <= 1'b0;
         radr_q       <= '0;
         wdata_q      <= '0;
         rbuf_q       <= '0;
         phi3_q       <= 1'b1;
         memen_q      <= 1'b1;
         dbin_q       <= 1'b0;
         we_q         <= 1'b1;
         a15_q        <= 1'b0;
         oaddr_q      <= '0;
         odata_q      <= '0;
         oe_q         <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         qtr_q        <= qtr_d;
         win_q        <= win_d;
         wr_q         <= wr_d;
         radr_q       <= radr_d;
         wdata_q      <= wdata_d;
         rbuf_q       <= rbuf_d;
         phi3_q       <= (qtr_d != 2'd2);
         memen_q      <= memen_d;
         dbin_q       <= dbin_d;
         we_q         <= we_d;
         a15_q        <= a15_d;
         oaddr_q      <= oaddr_d;
         odata_q      <= odata_d;
         oe_q         <= oe_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign phi3       = phi3_q;
   assign memen      = memen_q;
   assign dbin       = dbin_q;
   assign we         = we_q;
   assign a15        = a15_q;
   assign o_address  = {oaddr_q, a15_q};
   assign o_data     = odata_q;
   assign o_data_oe  = oe_q;

endmodule

// File: tb/tb_tms9900_bus_master.sv
// Scoreboard bench for tms9900_bus_master: random and directed word requests against a memory responder.
module tb_tms9900_bus_master;
   localparam int CPP  = 2;
   localparam int WS   = 2;
   localparam int TO   = 4;
   localparam int TCLK = 4 * CPP;
`ifdef BUS_MASTER_READY_EN
   localparam bit READY_EN = 1'b1;
`else
   localparam bit READY_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [15:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [15:0] resp_rdata;
   logic        phi3, memen, dbin, we, a15, o_data_oe, ready;
   logic [15:0] o_address;
   logic [7:0]  o_data, i_data;

   always #5 clk = ~clk;

   tms9900_bus_master #(.CLK_PER_PHASE(CPP), .WAIT_STATES(WS), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .phi3(phi3), .memen(memen), .dbin(dbin), .we(we), .a15(a15),
      .o_address(o_address), .o_data(o_data), .o_data_oe(o_data_oe),
      .i_data(i_data), .ready(ready)
   );

   logic [7:0] mem [0:65535];
   assign i_data = mem[o_address];

   typedef struct {bit err; bit chk; logic [15:0] rdata;} resp_t;
   typedef struct {int len; bit dbin; int wes;} cyc_t;
   typedef struct {logic [15:0] addr; logic [7:0] data;} wr_t;

   resp_t       exp_resp[$];
   cyc_t        exp_cyc[$];
   wr_t         exp_wr[$];
   logic [15:0] last_rdata = 16'h0;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_outs"}, {phi3, memen, dbin, we, a15, o_data_oe, resp_valid, resp_err}, 8'b1101_0000);
      check({name, "_addr_data"}, {o_address, o_data}, 24'h0);
      check({name, "_rdata"}, resp_rdata, 16'h0);
      check({name, "_req_ready"}, req_ready, 1'b1);
   endtask

   // Expected cycle derived from the bus rules: address T, two byte windows, plus extensions.
   task automatic issue(input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input int ext, input bit abrt, input bit hold);
      logic [15:0] aw, rd;
      int n;
      aw = {a[15:1], 1'b0};
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      n = 0;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      if (!req_ready) begin
         check("req_accept_wait", req_ready, 1'b1);
         req_valid = 1'b0;
         return;
      end
      if (wr) begin
         exp_wr.push_back('{aw, d[15:8]});
         exp_wr.push_back('{aw | 16'h1, d[7:0]});
      end
      if (abrt) begin
         exp_cyc.push_back('{TCLK * (1 + WS + TO), !wr, 0});
         exp_resp.push_back('{1'b1, 1'b1, last_rdata});
      end else begin
         exp_cyc.push_back('{TCLK * (1 + 2 * WS + ext), !wr, wr ? 2 : 0});
         if (wr) exp_resp.push_back('{1'b0, 1'b0, 16'h0});
         else begin
            rd = {mem[aw], mem[aw | 16'h1]};
            last_rdata = rd;
            exp_resp.push_back('{1'b0, 1'b1, rd});
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("req_ready_busy", req_ready, 1'b0);
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_resp.size() + exp_cyc.size() + exp_wr.size()) != 0 && n < 1000) begin
         @(negedge clk); n++;
      end
      check("drain_pending", exp_resp.size() + exp_cyc.size() + exp_wr.size(), 0);
   endtask

   int          lo_cnt, hi_cnt, we_len, we_cnt;
   bit          prev_memen = 1'b1, prev_we = 1'b1, seen_cyc = 1'b0, viol = 1'b0, cyc_dbin = 1'b0;
   logic [15:0] we_a;
   logic [7:0]  we_dat;
   resp_t       m_r;
   cyc_t        m_c;
   wr_t         m_w;

   always @(negedge clk) begin
      if (reset) begin
         prev_memen = 1'b1; prev_we = 1'b1; seen_cyc = 1'b0; viol = 1'b0;
         lo_cnt = 0; hi_cnt = 0; we_len = 0; we_cnt = 0;
      end else begin
         if (resp_valid) begin
            if (exp_resp.size() == 0) check("resp_unexpected", 1'b1, 1'b0);
            else begin
               m_r = exp_resp.pop_front();
               check("resp_err", resp_err, m_r.err);
               if (m_r.chk) check("resp_rdata", resp_rdata, m_r.rdata);
            end
         end
         if (!we) begin
            if (prev_we) begin we_len = 0; we_cnt++; end
            we_len++;
            we_a = o_address; we_dat = o_data;
            if (!o_data_oe || memen) viol = 1'b1;
         end else if (!prev_we) begin
            if (exp_wr.size() == 0) check("wr_unexpected", 1'b1, 1'b0);
            else begin
               m_w = exp_wr.pop_front();
               check("wr_addr", we_a, m_w.addr);
               check("wr_data", we_dat, m_w.data);
               check("we_len_clk", we_len, TCLK * (WS - 1));
            end
         end
         if (!memen) begin
            if (prev_memen) begin
               if (seen_cyc) check("memen_gap_ok", hi_cnt >= TCLK, 1'b1);
               lo_cnt = 0; cyc_dbin = dbin;
            end
            lo_cnt++;
            if (dbin !== cyc_dbin || (dbin && (!we || o_data_oe)) || req_ready) viol = 1'b1;
         end else begin
            if (!prev_memen) begin
               if (exp_cyc.size() == 0) check("cycle_unexpected", 1'b1, 1'b0);
               else begin
                  m_c = exp_cyc.pop_front();
                  check("memen_low_clk", lo_cnt, m_c.len);
                  check("cycle_dbin", cyc_dbin, m_c.dbin);
                  check("we_pulses", we_cnt, m_c.wes);
                  check("protocol", viol, 1'b0);
               end
               seen_cyc = 1'b1; hi_cnt = 0; we_cnt = 0; viol = 1'b0;
            end
            hi_cnt++;
            if (!we || o_data_oe) viol = 1'b1;
         end
         prev_memen = memen; prev_we = we;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit hold;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; ready = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'hA000] = 8'h12; mem[16'hA001] = 8'h34;
      repeat (3) @(negedge clk);
      check_reset_vals("rst_init");
      reset = 1'b0;

      n = 0;
      repeat (4 * TCLK) begin @(negedge clk); if (!phi3) n++; end
      check("phi3_low_clks", n, 4 * CPP);

      issue(1'b0, 16'hA000, 16'h0, 0, 1'b0, 1'b0);
      drain();
      check("t1_rdata", resp_rdata, 16'h1234);

      issue(1'b1, 16'h2000, 16'hBEEF, 0, 1'b0, 1'b0);
      drain();

      ready = 1'b0;
      fork
         issue(1'b0, 16'h5A5A, 16'h0, READY_EN ? 3 : 0, 1'b0, 1'b0);
         begin
            for (int k = 0; k < 200 && memen; k++) @(negedge clk);
            repeat (44) @(negedge clk);
            ready = 1'b1;
         end
      join
      drain();

      ready = 1'b0;
      issue(1'b0, 16'($urandom), 16'h0, 0, READY_EN, 1'b0);
      drain();
      ready = 1'b1;
      check("t4_memen_high", memen, 1'b1);

      for (int i = 0; i < 3; i++) issue(1'($urandom), 16'($urandom), 16'($urandom), 0, 1'b0, 1'b1);
      issue(1'b0, 16'($urandom), 16'h0, 0, 1'b0, 1'b0);
      drain();

      issue(1'b1, 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
      n = 0;
      while (!(a15 && !memen) && n < 200) begin @(negedge clk); n++; end
      check("rst_reach_lo", a15 && !memen, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_async", {memen, we, o_data_oe, resp_valid}, 4'b1100);
      exp_wr.delete(); exp_resp.delete(); exp_cyc.delete();
      last_rdata = 16'h0;
      repeat (3) @(negedge clk);
      check_reset_vals("rst_mid");
      reset = 1'b0;
      issue(1'b0, 16'hA001, 16'h0, 0, 1'b0, 1'b0);
      drain();
      check("post_rst_rdata", resp_rdata, 16'h1234);

      for (int i = 0; i < 24; i++) begin
         hold  = (i != 23) && ($urandom_range(0, 3) == 0);
         ready = READY_EN ? 1'b1 : 1'($urandom_range(0, 1));
         issue(1'($urandom), 16'($urandom), 16'($urandom), 0, 1'b0, hold);
         if (!hold) repeat ($urandom_range(0, 10)) @(negedge clk);
      end
      req_valid = 1'b0;
      ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
